// File: rtl/transpose_fifo_ctrl_if.sv
// Row handshake plus per-FIFO load/shift strobes between the transpose controller and its FIFO bank.
interface transpose_fifo_ctrl_if #(
   parameter int DIM = 8
);
   logic           row_valid;
   logic           row_ready;
   logic           hold;
   logic           feed_valid;
   logic [DIM-1:0] wr_en;
   logic [DIM-1:0] shift_en;

   modport master (
      input  row_valid,
      input  hold,
      output row_ready,
      output wr_en,
      output shift_en,
      output feed_valid
   );

   modport slave (
      output row_valid,
      output hold,
      input  row_ready,
      input  wr_en,
      input  shift_en,
      input  feed_valid
   );
endinterface

// File: rtl/transpose_fifo_ctrl.sv
// Loads DIM rows into the transpose FIFOs, then drains them as a diagonally skewed wavefront.
// wr_en is same-cycle on accept; drain freezes on hold; abort returns to IDLE with all strobes gated off.
module transpose_fifo_ctrl #(
   parameter int DIM = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   output logic busy,
   output logic done,
   transpose_fifo_ctrl_if.master bus
);
   localparam int RW = $clog2(DIM) + 1;
   localparam int DW = $clog2(2 * DIM);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] row_cnt, row_cnt_nxt;
   logic [DW-1:0] drain_cnt, drain_cnt_nxt;

   logic           row_ready;
   logic           feed_valid;
   logic [DIM-1:0] wr_en;
   logic [DIM-1:0] shift_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         row_cnt   <= row_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      row_cnt_nxt   = row_cnt;
      drain_cnt_nxt = drain_cnt;
      row_ready     = 1'b0;
      feed_valid    = 1'b0;
      wr_en         = '0;
      shift_en      = '0;
      busy          = (state != IDLE);
      done          = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = LOAD;
               row_cnt_nxt = '0;
            end
         end
         LOAD: begin
            row_ready = 1'b1;
            if (bus.row_valid) begin
               wr_en       = DIM'(1) << row_cnt;
               row_cnt_nxt = row_cnt + RW'(1);
               if (row_cnt == RW'(DIM - 1)) begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = '0;
               end
            end
         end
         DRAIN: begin
            if (!bus.hold) begin
               feed_valid = 1'b1;
               // FIFO i is live for DIM cycles starting i cycles after FIFO 0.
               for (int i = 0; i < DIM; i++) begin
                  shift_en[i] = (int'(drain_cnt) >= i) && (int'(drain_cnt) <= i + DIM - 1);
               end
               drain_cnt_nxt = drain_cnt + DW'(1);
               if (drain_cnt == DW'(2 * DIM - 2)) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (abort) begin
         state_nxt     = IDLE;
         row_cnt_nxt   = '0;
         drain_cnt_nxt = '0;
         row_ready     = 1'b0;
         feed_valid    = 1'b0;
         wr_en         = '0;
         shift_en      = '0;
      end
   end

   assign bus.row_ready  = row_ready;
   assign bus.feed_valid = feed_valid;
   assign bus.wr_en      = wr_en;
   assign bus.shift_en   = shift_en;
endmodule

// File: tb/tb_transpose_fifo_ctrl.sv
// Directed bench for transpose_fifo_ctrl at DIM=4 with hand-computed load/drain patterns.
module tb_transpose_fifo_ctrl;
   localparam int DIM = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy;
   logic done;

   int checks = 0;
   int errors = 0;

   logic [DIM-1:0] load_exp  [DIM];
   logic [DIM-1:0] drain_exp [2*DIM-1];

   transpose_fifo_ctrl_if #(.DIM(DIM)) bus();

   transpose_fifo_ctrl #(.DIM(DIM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Apply inputs for the current cycle and let combinational outputs settle.
   task automatic drive(input logic s, input logic rv, input logic h, input logic a);
      start = s;
      bus.row_valid = rv;
      bus.hold = h;
      abort = a;
      #3;
   endtask

   task automatic test_reset();
      bus.row_valid = 1'b0;
      bus.hold = 1'b0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      drive(1, 0, 0, 0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
      next_cycle();
      drive(0, 1, 0, 0);
      checks++; if (bus.wr_en !== 4'b0001) begin errors++; $display("FAIL reset_pre_wr_en: got %b want 0001", bus.wr_en); end
      next_cycle();
      drive(1'($urandom), 1'($urandom), 1'($urandom), 0);
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (bus.row_ready !== 1'b0) begin errors++; $display("FAIL reset_row_ready: got %b want 0", bus.row_ready); end
      checks++; if (bus.wr_en !== 4'b0000) begin errors++; $display("FAIL reset_wr_en: got %b want 0000", bus.wr_en); end
      checks++; if (bus.shift_en !== 4'b0000) begin errors++; $display("FAIL reset_shift_en: got %b want 0000", bus.shift_en); end
      checks++; if (bus.feed_valid !== 1'b0) begin errors++; $display("FAIL reset_feed_valid: got %b want 0", bus.feed_valid); end
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0);
         checks++; if (busy !== 1'b0 || bus.row_ready !== 1'b0) begin errors++; $display("FAIL reset_stay_idle[%0d]: busy=%b row_ready=%b want 0 0", i, busy, bus.row_ready); end
         next_cycle();
      end
   endtask

   task automatic test_load_drain();
      drive(1, 0, 0, 0);
      next_cycle();
      for (int i = 0; i < DIM; i++) begin
         drive(0, 1, 0, 0);
         checks++; if (bus.wr_en !== load_exp[i]) begin errors++; $display("FAIL load_wr_en[%0d]: got %b want %b", i, bus.wr_en, load_exp[i]); end
         checks++; if (bus.row_ready !== 1'b1) begin errors++; $display("FAIL load_row_ready[%0d]: got %b want 1", i, bus.row_ready); end
         next_cycle();
      end
      for (int i = 0; i < 2*DIM-1; i++) begin
         drive(0, 0, 0, 0);
         checks++; if (bus.shift_en !== drain_exp[i]) begin errors++; $display("FAIL drain_shift_en[%0d]: got %b want %b", i, bus.shift_en, drain_exp[i]); end
         checks++; if (bus.feed_valid !== 1'b1 || bus.row_ready !== 1'b0 || bus.wr_en !== 4'b0000) begin errors++; $display("FAIL drain_ctrl[%0d]: feed_valid=%b row_ready=%b wr_en=%b want 1 0 0000", i, bus.feed_valid, bus.row_ready, bus.wr_en); end
         next_cycle();
      end
      drive(0, 0, 0, 0);
      checks++; if (done !== 1'b1 || busy !== 1'b1 || bus.shift_en !== 4'b0000) begin errors++; $display("FAIL drain_done: done=%b busy=%b shift_en=%b want 1 1 0000", done, busy, bus.shift_en); end
      next_cycle();
      drive(0, 0, 0, 0);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL drain_idle: busy=%b done=%b want 0 0", busy, done); end
      next_cycle();
   endtask

   task automatic test_stalls();
      logic           rv_pat   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [DIM-1:0] wr_pat   [6] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b1000};
      logic [DIM-1:0] sh_pat   [8] = '{4'b0001, 4'b0011, 4'b0000, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      logic           h;
      drive(1, 0, 0, 0);
      next_cycle();
      for (int i = 0; i < 6; i++) begin
         drive(0, rv_pat[i], 0, 0);
         checks++; if (bus.wr_en !== wr_pat[i]) begin errors++; $display("FAIL stall_wr_en[%0d]: got %b want %b", i, bus.wr_en, wr_pat[i]); end
         next_cycle();
      end
      for (int i = 0; i < 8; i++) begin
         h = (i == 2);
         drive(0, 0, h, 0);
         checks++; if (bus.shift_en !== sh_pat[i]) begin errors++; $display("FAIL stall_shift_en[%0d]: got %b want %b", i, bus.shift_en, sh_pat[i]); end
         checks++; if (bus.feed_valid !== !h || done !== 1'b0) begin errors++; $display("FAIL stall_feed_valid[%0d]: feed_valid=%b done=%b want %b 0", i, bus.feed_valid, done, !h); end
         next_cycle();
      end
      drive(0, 0, 0, 0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
      next_cycle();
   endtask

   task automatic test_start_abort();
      int dones;
      drive(1, 0, 0, 0);
      next_cycle();
      for (int i = 0; i < DIM; i++) begin
         drive(0, 1, 0, 0);
         next_cycle();
      end
      dones = 0;
      for (int j = 0; j < 14; j++) begin
         drive(j < 8, 0, 0, 0);
         if (done === 1'b1) dones++;
         next_cycle();
      end
      checks++; if (dones !== 1) begin errors++; $display("FAIL start_ignored_dones: got %0d want 1", dones); end
      drive(0, 0, 0, 0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_ignored_idle: busy=%b want 0", busy); end

      drive(1, 0, 0, 0);
      next_cycle();
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 0);
         checks++; if (bus.wr_en !== load_exp[i]) begin errors++; $display("FAIL abort_pre_wr_en[%0d]: got %b want %b", i, bus.wr_en, load_exp[i]); end
         next_cycle();
      end
      drive(0, 1, 0, 1);
      checks++; if (bus.wr_en !== 4'b0000 || bus.row_ready !== 1'b0) begin errors++; $display("FAIL abort_cycle: wr_en=%b row_ready=%b want 0000 0", bus.wr_en, bus.row_ready); end
      next_cycle();
      dones = 0;
      for (int j = 0; j < 4; j++) begin
         drive(0, 0, 0, 0);
         if (done === 1'b1 || busy === 1'b1) dones++;
         next_cycle();
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL abort_idle: got %0d busy/done cycles want 0", dones); end
      drive(1, 0, 0, 0);
      next_cycle();
      drive(0, 1, 0, 0);
      checks++; if (bus.wr_en !== 4'b0001) begin errors++; $display("FAIL abort_restart_wr_en: got %b want 0001", bus.wr_en); end
      next_cycle();
      drive(0, 0, 0, 1);
      next_cycle();
      drive(0, 0, 0, 0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_cleanup: busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid_drain();
      drive(1, 0, 0, 0);
      next_cycle();
      for (int i = 0; i < DIM; i++) begin
         drive(0, 1, 0, 0);
         next_cycle();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0);
         checks++; if (bus.shift_en !== drain_exp[i]) begin errors++; $display("FAIL mid_pre_shift_en[%0d]: got %b want %b", i, bus.shift_en, drain_exp[i]); end
         next_cycle();
      end
      drive(0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.shift_en !== 4'b0000 || bus.feed_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: busy=%b done=%b shift_en=%b feed_valid=%b want 0 0 0000 0", busy, done, bus.shift_en, bus.feed_valid); end
      next_cycle();
      rst_n = 1'b1;
      drive(1, 0, 0, 0);
      next_cycle();
      for (int i = 0; i < DIM; i++) begin
         drive(0, 1, 0, 0);
         checks++; if (bus.wr_en !== load_exp[i]) begin errors++; $display("FAIL mid_reload_wr_en[%0d]: got %b want %b", i, bus.wr_en, load_exp[i]); end
         next_cycle();
      end
      for (int i = 0; i < 2*DIM-1; i++) begin
         drive(0, 0, 0, 0);
         checks++; if (bus.shift_en !== drain_exp[i]) begin errors++; $display("FAIL mid_redrain_shift_en[%0d]: got %b want %b", i, bus.shift_en, drain_exp[i]); end
         next_cycle();
      end
      drive(0, 0, 0, 0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_redone: got %b want 1", done); end
      next_cycle();
   endtask

   initial begin
      load_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      drain_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      bus.row_valid = 1'b0;
      bus.hold = 1'b0;
      test_reset();
      test_load_drain();
      test_stalls();
      test_start_abort();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/transpose_fifo_ctrl.md
Name: transpose_fifo_ctrl

Overview:
- Sequencer for the bank of DIM transpose FIFOs that feeds the systolic array.
- Accepts DIM matrix rows over a valid/ready handshake and pulses the matching FIFO's parallel-load write enable for each row.
- Then drives the per-FIFO shift enables in a diagonal skew (FIFO i starts i cycles after FIFO 0), so the array receives a correctly staggered wavefront.
- Supports stall (hold) from the array and synchronous abort.

Parameters:
- DIM, 8, number of FIFOs, equal to FIFO depth and to the matrix dimension; must be ≥2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a load+drain sequence; sampled only in IDLE
- abort  input  1  synchronous abort to IDLE; wins over all other inputs
- row_valid  input  1  upstream presents a row (row data goes straight to FIFO rowIn)
- row_ready  output  1  controller accepts a row this cycle
- hold  input  1  array stall; freezes the drain
- wr_en  output  DIM  one-hot parallel-load enable, bit i to FIFO i
- shift_en  output  DIM  per-FIFO shift enable, bit i to FIFO i
- feed_valid  output  1  FIFO outputs carry a valid skewed wavefront this cycle
- busy  output  1  state is not IDLE
- done  output  1  single-cycle completion pulse

Behaviour:
- States: IDLE, LOAD, DRAIN, DONE; 2-bit state register.
- Counters: row_cnt, width $clog2(DIM)+1; drain_cnt, width $clog2(2*DIM).
- Reset (async): state=IDLE, both counters 0. All outputs are 0 while in reset and in IDLE.
- IDLE:
  - start=1 at a clock edge → LOAD; row_cnt cleared.
  - start in any other state is ignored.
- LOAD:
  - row_ready=1.
  - Accept when row_valid&row_ready: wr_en = one-hot(row_cnt) in the same cycle (combinational from the registered row_cnt and row_valid), then row_cnt increments.
  - wr_en=0 on cycles without an accept; gaps in row_valid are allowed.
  - On the accept with row_cnt==DIM-1: → DRAIN, drain_cnt=0. row_ready is 0 from the next cycle.
- DRAIN: total span 2*DIM-1 active cycles.
  - Active cycle (hold=0): shift_en[i]=1 iff i ≤ drain_cnt ≤ i+DIM-1; feed_valid=1; drain_cnt increments.
  - hold=1: shift_en=0, feed_valid=0, drain_cnt held.
  - On the active cycle with drain_cnt==2*DIM-2: → DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then → IDLE.
  - start asserted during DONE is ignored; a new start is honoured from the first IDLE cycle.
- busy=1 in LOAD, DRAIN and DONE.
- wr_en and shift_en are never nonzero in the same cycle. Each FIFO receives exactly DIM shift pulses per sequence.
- abort=1 in any state:
  - Next state is IDLE and counters clear.
  - In the abort cycle itself, wr_en, shift_en, row_ready and feed_valid are forced to 0, so no row is accepted.
  - No done pulse is generated.
- Async reset mid-sequence: outputs drop to 0 immediately; no done pulse.
- Outputs are Moore-decoded from registered state/counters, except wr_en (gated by row_valid) and shift_en/feed_valid (gated by hold).

Test Plan:
- Reset: assert rst_n=0 mid-cycle with random inputs → busy, done, row_ready, wr_en, shift_en, feed_valid all 0 immediately; after release, stays IDLE until start.
- Load, DIM=4, start then row_valid held 1 → wr_en = 0001,0010,0100,1000 on four consecutive cycles; row_ready=0 on the 5th; state DRAIN.
- Drain, DIM=4, hold=0 → shift_en = 0001,0011,0111,1111,1110,1100,1000 over 7 cycles, feed_valid=1 on all 7; done=1 on the 8th cycle; busy=0 on the 9th.
- Stalls, DIM=4: row_valid pattern 1,0,1,0,1,1 → wr_en only on valid cycles, in order 0001,0010,0100,1000. hold=1 on the 3rd drain cycle → shift_en=0 that cycle and the 0111 pattern repeats after; 8 drain-phase cycles total before done.
- Start/abort: start pulsed during DRAIN → ignored, exactly one done. abort after 2 loaded rows → IDLE next cycle, wr_en=0 in the abort cycle, no done; a new start then loads from wr_en=0001.
- Reset mid-drain (after shift_en=0011) → all outputs 0. A subsequent full sequence matches the Load and Drain patterns above exactly.
